// File: rtl/exc_handler.sv
// Exception/interrupt sequencer: qualifies program errors and external
// interrupts, drains the pipe, saves state, vectors, and handles rfi.
// Ports:
//   clk, rst (async, active-low)
//   progErr/progEsr : program-error request and cause {PIL,PPR,PTR}
//   extIrq          : external interrupt level (gated by MSR[15] EE)
//   MSR             : current machine state
//   excPC / nextPC  : faulting PC / next unexecuted PC
//   drained         : pipeline empty of younger instructions
//   rfi             : return-from-interrupt strobe
//   IVPR/IVOR6/4    : vector prefix and offsets
//   ack             : one-cycle acknowledge for program errors
//   stall / busy    : high in every non-IDLE state
//   pc_wr / pc_new  : PC redirect strobe and target
//   msr_wr/msr_new  : MSR write strobe and value
//   srr0/srr1/esr   : architected save registers
module exc_handler (
  input  logic        clk,
  input  logic        rst,
  input  logic        progErr,
  input  logic [2:0]  progEsr,
  input  logic        extIrq,
  input  logic [31:0] MSR,
  input  logic [31:0] excPC,
  input  logic [31:0] nextPC,
  input  logic        drained,
  input  logic        rfi,
  input  logic [31:0] IVPR,
  input  logic [31:0] IVOR6,
  input  logic [31:0] IVOR4,
  output logic        ack,
  output logic        stall,
  output logic        busy,
  output logic        pc_wr,
  output logic [31:0] pc_new,
  output logic        msr_wr,
  output logic [31:0] msr_new,
  output logic [31:0] srr0,
  output logic [31:0] srr1,
  output logic [31:0] esr
);

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    SAVE,
    VECTOR,
    ACK
  } state_t;

  state_t      state;
  state_t      nextState;
  logic        causeProg;
  logic [2:0]  causeEsr;
  logic        ackMask;
  logic        progReq;
  logic        extReq;
  logic        req;
  logic [31:0] ivor;

  // ackMask blocks a still-held progErr right after its own ACK
  assign progReq = progErr & ~ackMask;
  assign extReq  = extIrq & MSR[15];
  assign req     = progReq | extReq;
  assign ivor    = causeProg ? IVOR6 : IVOR4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      causeProg <= 1'b0;
      causeEsr  <= 3'b000;
      ackMask   <= 1'b0;
      srr0      <= 32'h0;
      srr1      <= 32'h0;
      esr       <= 32'h0;
    end else begin
      state   <= nextState;
      ackMask <= (state == ACK);
      if (state == IDLE && req) begin
        causeProg <= progReq;
        causeEsr  <= progEsr;
      end
      if (state == SAVE) begin
        srr0 <= causeProg ? excPC : nextPC;
        srr1 <= MSR;
        if (causeProg)
          esr <= {4'b0000, causeEsr, 25'b0};
      end
    end
  end

  always_comb begin
    nextState = state;
    ack       = 1'b0;
    stall     = 1'b1;
    busy      = 1'b1;
    pc_wr     = 1'b0;
    pc_new    = 32'h0;
    msr_wr    = 1'b0;
    msr_new   = 32'h0;
    unique case (state)
      IDLE: begin
        stall = 1'b0;
        busy  = 1'b0;
        if (req) begin
          nextState = FLUSH;
        end else if (rfi) begin
          pc_wr   = 1'b1;
          pc_new  = srr0;
          msr_wr  = 1'b1;
          msr_new = srr1;
        end
      end
      FLUSH: begin
        if (drained)
          nextState = SAVE;
      end
      SAVE: begin
        nextState = VECTOR;
      end
      VECTOR: begin
        pc_wr     = 1'b1;
        pc_new    = {IVPR[31:16], ivor[15:4], 4'b0000};
        msr_wr    = 1'b1;
        msr_new   = MSR & ~32'h0000_C000;
        nextState = ACK;
      end
      ACK: begin
        ack       = causeProg;
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_exc_handler.sv
// Directed bench for exc_handler with an expected-redirect scoreboard.
// Immediate assertions at every comparison point.
module tb_exc_handler;

  logic        clk;
  logic        rst;
  logic        progErr;
  logic [2:0]  progEsr;
  logic        extIrq;
  logic [31:0] MSR;
  logic [31:0] excPC;
  logic [31:0] nextPC;
  logic        drained;
  logic        rfi;
  logic [31:0] IVPR;
  logic [31:0] IVOR6;
  logic [31:0] IVOR4;
  logic        ack;
  logic        stall;
  logic        busy;
  logic        pc_wr;
  logic [31:0] pc_new;
  logic        msr_wr;
  logic [31:0] msr_new;
  logic [31:0] srr0;
  logic [31:0] srr1;
  logic [31:0] esr;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] msr;
    logic        ack;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  exc_handler dut (
    .clk     (clk),
    .rst     (rst),
    .progErr (progErr),
    .progEsr (progEsr),
    .extIrq  (extIrq),
    .MSR     (MSR),
    .excPC   (excPC),
    .nextPC  (nextPC),
    .drained (drained),
    .rfi     (rfi),
    .IVPR    (IVPR),
    .IVOR6   (IVOR6),
    .IVOR4   (IVOR4),
    .ack     (ack),
    .stall   (stall),
    .busy    (busy),
    .pc_wr   (pc_wr),
    .pc_new  (pc_new),
    .msr_wr  (msr_wr),
    .msr_new (msr_new),
    .srr0    (srr0),
    .srr1    (srr1),
    .esr     (esr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic allZero(input string tag);
    chk({tag, "_ack"}, {31'b0, ack}, 32'h0);
    chk({tag, "_stall"}, {31'b0, stall}, 32'h0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
    chk({tag, "_pcwr"}, {31'b0, pc_wr}, 32'h0);
    chk({tag, "_msrwr"}, {31'b0, msr_wr}, 32'h0);
    chk({tag, "_srr0"}, srr0, 32'h0);
    chk({tag, "_srr1"}, srr1, 32'h0);
    chk({tag, "_esr"}, esr, 32'h0);
  endtask

  // Request inputs must already be driven; hold = FLUSH cycles with
  // drained low, expLat = cycle (after the request edge) of pc_wr.
  task automatic runSeq(input string tag, input int hold,
                        input int expLat);
    exp_t e;
    int   cyc;
    bit   seen;
    cyc = 0;
    seen = 0;
    drained = (hold == 0);
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      cyc++;
      rfi = 1'b0;
      if (pc_wr) begin
        seen = 1;
      end else begin
        chk({tag, "_stall"}, {31'b0, stall}, 32'h1);
        if (cyc >= hold) drained = 1'b1;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $error("FAIL %s_timeout observed=no_pc_wr expected=pc_wr", tag);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk({tag, "_lat"}, cyc, expLat);
      chk({tag, "_pcnew"}, pc_new, e.pc);
      chk({tag, "_msrwr"}, {31'b0, msr_wr}, 32'h1);
      chk({tag, "_msrnew"}, msr_new, e.msr);
      extIrq = 1'b0;
      tick();
      chk({tag, "_ack"}, {31'b0, ack}, {31'b0, e.ack});
      chk({tag, "_ackbusy"}, {31'b0, busy}, 32'h1);
      tick();
      chk({tag, "_mask_busy"}, {31'b0, busy}, 32'h0);
      chk({tag, "_mask_ack"}, {31'b0, ack}, 32'h0);
      progErr = 1'b0;
      tick();
      chk({tag, "_idle_busy"}, {31'b0, busy}, 32'h0);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    progErr = 1'b0;
    progEsr = 3'b000;
    extIrq = 1'b0;
    MSR = 32'h0;
    excPC = 32'h0;
    nextPC = 32'h0;
    drained = 1'b1;
    rfi = 1'b0;
    IVPR = 32'hFFFF_0000;
    IVOR6 = 32'h0000_0700;
    IVOR4 = 32'h0000_0500;
    #12;
    allZero("reset");
    rst = 1'b1;
    tick();
    chk("postrst_busy", {31'b0, busy}, 32'h0);

    // Program error, minimum latency, progErr held past ACK
    MSR = 32'h0000_C000;
    excPC = 32'h100;
    progEsr = 3'b100;
    progErr = 1'b1;
    sb.push_back('{32'hFFFF_0700, 32'h0, 1'b1});
    runSeq("prog", 0, 3);
    chk("prog_srr0", srr0, 32'h100);
    chk("prog_srr1", srr1, 32'hC000);
    chk("prog_esr", esr, 32'h0800_0000);

    // External interrupt, EE set
    MSR = 32'h0000_8000;
    nextPC = 32'h204;
    extIrq = 1'b1;
    sb.push_back('{32'hFFFF_0500, 32'h0, 1'b0});
    runSeq("ext", 0, 3);
    chk("ext_srr0", srr0, 32'h204);
    chk("ext_srr1", srr1, 32'h8000);
    chk("ext_esr", esr, 32'h0800_0000);

    // External interrupt with EE clear is ignored
    MSR = 32'h0;
    extIrq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("extmask_busy", {31'b0, busy}, 32'h0);
      chk("extmask_pcwr", {31'b0, pc_wr}, 32'h0);
    end
    extIrq = 1'b0;

    // Both requests, pipe not drained for 5 cycles: PROG wins
    MSR = 32'h0000_8000;
    excPC = 32'h140;
    nextPC = 32'h2C0;
    progEsr = 3'b010;
    progErr = 1'b1;
    extIrq = 1'b1;
    sb.push_back('{32'hFFFF_0700, 32'h0, 1'b1});
    runSeq("both", 5, 7);
    chk("both_srr0", srr0, 32'h140);
    chk("both_esr", esr, 32'h0400_0000);

    // Load srr0/srr1 via an external interrupt, then rfi
    MSR = 32'h0000_8000;
    nextPC = 32'h300;
    extIrq = 1'b1;
    sb.push_back('{32'hFFFF_0500, 32'h0, 1'b0});
    runSeq("ext2", 0, 3);
    rfi = 1'b1;
    #1;
    chk("rfi_pcwr", {31'b0, pc_wr}, 32'h1);
    chk("rfi_pcnew", pc_new, 32'h300);
    chk("rfi_msrwr", {31'b0, msr_wr}, 32'h1);
    chk("rfi_msrnew", msr_new, 32'h8000);
    tick();
    rfi = 1'b0;
    #1;
    chk("rfi_busy", {31'b0, busy}, 32'h0);
    chk("rfi_done_pcwr", {31'b0, pc_wr}, 32'h0);
    chk("rfi_done_pcnew", pc_new, 32'h0);

    // rfi coincident with a program error loses
    excPC = 32'h180;
    progEsr = 3'b001;
    progErr = 1'b1;
    rfi = 1'b1;
    #1;
    chk("rfiprog_pcwr", {31'b0, pc_wr}, 32'h0);
    sb.push_back('{32'hFFFF_0700, 32'h0, 1'b1});
    runSeq("rfiprog", 0, 3);
    chk("rfiprog_srr0", srr0, 32'h180);
    chk("rfiprog_esr", esr, 32'h0200_0000);

    // Reset during SAVE aborts the sequence
    progErr = 1'b1;
    drained = 1'b1;
    tick();
    tick();
    chk("midrst_busy", {31'b0, busy}, 32'h1);
    rst = 1'b0;
    #1;
    allZero("midrst");
    progErr = 1'b0;
    #3;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("after_ack", {31'b0, ack}, 32'h0);
      chk("after_pcwr", {31'b0, pc_wr}, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exc_handler.md
EXC_HANDLER -- requirements
Module: exc_handler

Interface
REQ-001 The block SHALL have ports: clk input 1 system clock; rst input 1 reset. One clock; reset is asynchronous and active-low.
REQ-002 progErr input 1 program-error request, level, held by requester until ack; progEsr input 3 cause {PIL,PPR,PTR}, valid while progErr=1.
REQ-003 extIrq input 1 external interrupt level; MSR input 32 current machine state; excPC input 32 PC of faulting instruction; nextPC input 32 PC of next unexecuted instruction.
REQ-004 drained input 1 pipeline empty of younger instructions; rfi input 1 one-cycle return-from-interrupt strobe; IVPR input 32; IVOR6 input 32; IVOR4 input 32.
REQ-005 ack output 1 request acknowledge; stall output 1 freeze fetch/issue; busy output 1 not in IDLE.
REQ-006 pc_wr output 1 PC redirect strobe; pc_new output 32 redirect target; msr_wr output 1 MSR write strobe; msr_new output 32 MSR value.
REQ-007 srr0 output 32, srr1 output 32, esr output 32: architected save registers, held internally.

Function
REQ-008 FSM states SHALL be IDLE, FLUSH, SAVE, VECTOR, ACK; one transition per rising clk edge.
REQ-009 Request qualification in IDLE SHALL be: progErr takes priority; else extIrq with MSR[15] (EE)=1; extIrq with EE=0 SHALL be ignored.
REQ-010 IDLE->FLUSH on a qualified request; cause (PROG/EXT) and progEsr SHALL be latched on that edge; later changes to the inputs SHALL NOT affect the sequence.
REQ-011 FLUSH SHALL remain until drained=1, then go to SAVE; no timeout.
REQ-012 SAVE (one cycle): srr0<=excPC (PROG) or nextPC (EXT); srr1<=MSR; esr<={4'b0, PIL,PPR,PTR, 25'b0} (bits 27,26,25) for PROG, esr unchanged for EXT.
REQ-013 VECTOR (one cycle): pc_wr=1, pc_new={IVPR[31:16], IVORn[15:4], 4'b0000} with n=6 (PROG) or 4 (EXT); msr_wr=1, msr_new=MSR with bits 15 (EE) and 14 (PR) cleared.
REQ-014 ACK (one cycle): ack=1 for PROG only, then unconditional return to IDLE; EXT SHALL produce no ack pulse.
REQ-015 ack SHALL be exactly one cycle wide per accepted program error.
REQ-016 stall SHALL be 1 and busy 1 in every non-IDLE state; 0 in IDLE.
REQ-017 Minimum latency: request seen in IDLE at edge 0 with drained=1 -> pc_wr at cycle 3, ack at cycle 4.
REQ-018 rfi in IDLE with no qualified request: same cycle pc_wr=1, pc_new=srr0, msr_wr=1, msr_new=srr1; state stays IDLE.
REQ-019 rfi coincident with a qualified request: request SHALL win, rfi ignored; rfi outside IDLE SHALL be ignored.
REQ-020 pc_wr, msr_wr SHALL be 0 in all other cases; pc_new/msr_new SHALL be 0 when the strobe is 0.
REQ-021 progErr still high in the IDLE cycle after ACK SHALL NOT start a second sequence (one-cycle post-ACK mask).

Reset
REQ-022 rst=0 SHALL asynchronously force IDLE, ack=0, stall=0, busy=0, pc_wr=0, msr_wr=0, srr0=srr1=esr=0, latched cause cleared.
REQ-023 rst asserted mid-sequence SHALL abort it with no further pc_wr, msr_wr or ack; operation resumes on the first edge after rst=1.

Verification
REQ-024 progErr=1, progEsr=3'b100, excPC=0x100, MSR=0x0000C000, IVPR=0xFFFF0000, IVOR6=0x00000700, drained=1 -> srr0=0x100, srr1=0xC000, esr=0x08000000, pc_new=0xFFFF0700, msr_new=0x0, ack at cycle 4.
REQ-025 extIrq=1, MSR=0x8000, nextPC=0x204, IVOR4=0x500 -> srr0=0x204, pc_new=0xFFFF0500, no ack; repeat with MSR=0 -> no activity.
REQ-026 progErr and extIrq together, drained=0 for 5 cycles -> FLUSH held 5 cycles with stall=1, PROG path taken.
REQ-027 srr0=0x300, srr1=0x8000, rfi pulse in IDLE -> same-cycle pc_new=0x300, msr_new=0x8000; rfi with progErr -> rfi ignored.
REQ-028 rst=0 during SAVE -> all outputs 0 immediately; no ack after release.
